// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and the LFSR-to-degrees mapping for the
// CORDIC theta generator.
package cordic_pkg;

  localparam int PHASE_W        = 27;
  localparam int THETA_W        = 32;
  localparam int THETA_FRAC_LSB = 0;
  localparam int THETA_FRAC_MSB = 15;
  localparam int THETA_INT_LSB  = 16;
  localparam int THETA_INT_MSB  = 26;

  localparam logic [PHASE_W-1:0] DEG360_Q16   = 27'd23592960;
  localparam logic [31:0]        LFSR_TAPS    = 32'h80200003;
  localparam logic [31:0]        LFSR_DEFAULT = 32'h1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  // Upper LFSR half scaled into 0..359 whole degrees; lower half is the fraction.
  function automatic logic [THETA_W-1:0] rand_theta(input logic [31:0] l);
    logic [24:0] p;
    p = 25'(l[31:16]) * 25'(360);
    return {5'd0, 2'd0, p[24:16], l[15:0]};
  endfunction

endpackage

// File: rtl/theta_lfsr32.sv
// 32-bit Galois LFSR (right shift) with seed load and advance enable.
module theta_lfsr32
  import cordic_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_adv,
  output logic [31:0] o_lfsr
);

  logic [31:0] r_lfsr;

  // An all-zero state would lock up, so a zero seed maps to the default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_lfsr <= LFSR_DEFAULT;
    else if (i_load) r_lfsr <= (i_seed == '0) ? LFSR_DEFAULT : i_seed;
    else if (i_adv)  r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/cordic_theta_gen.sv
// Theta word source for the CORDIC modulator: NCO or LFSR phase, issued
// against a credit counter returned by the modulator's output handshake.
module cordic_theta_gen
  import cordic_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 1,
  parameter int LEN_W           = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [LEN_W-1:0]   len,
  input  logic [PHASE_W-1:0] phase_init,
  input  logic [PHASE_W-1:0] phase_step,
  input  logic [31:0]        seed,
  input  logic               seed_load,
  input  logic               done_i,
  output logic [THETA_W-1:0] theta,
  output logic               rand_shake,
  output logic               busy,
  output logic               burst_done,
  output logic [3:0]         outstanding
);

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_e             r_state;
  logic [LEN_W-1:0]   r_remain;
  logic [PHASE_W-1:0] r_acc;
  logic [3:0]         r_out;
  logic [THETA_W-1:0] r_theta;
  logic               r_shake;
  logic               r_bdone;

  logic               w_issue;
  logic               w_dec;
  logic [PHASE_W:0]   w_sum;
  logic [PHASE_W-1:0] w_acc_next;
  logic [31:0]        w_lfsr;
  logic [THETA_W-1:0] w_theta;

  // Credit is judged on the registered count only; a same-cycle done_i frees
  // a slot for the next cycle, never this one.
  assign w_issue = (r_state == RUN) && (r_out < MAX_OUT) && !abort;
  assign w_dec   = done_i && (r_out != '0);

  assign w_sum      = {1'b0, r_acc} + {1'b0, phase_step};
  assign w_acc_next = (w_sum >= {1'b0, DEG360_Q16}) ? PHASE_W'(w_sum - {1'b0, DEG360_Q16})
                                                    : w_sum[PHASE_W-1:0];
  assign w_theta    = mode ? rand_theta(w_lfsr) : {5'd0, r_acc};

  theta_lfsr32 u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (seed_load && (r_state == IDLE)),
    .i_seed (seed),
    .i_adv  (w_issue && mode),
    .o_lfsr (w_lfsr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_remain <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        IDLE: if (start && (len != '0)) begin
          r_state  <= RUN;
          r_remain <= len;
          r_acc    <= phase_init;
        end
        RUN: if (abort) begin
          r_state <= DRAIN;
        end else if (w_issue) begin
          r_remain <= r_remain - LEN_W'(1);
          if (!mode) r_acc <= w_acc_next;
          if (r_remain == LEN_W'(1)) r_state <= DRAIN;
        end
        DRAIN: if (r_out == '0) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      case ({w_issue, w_dec})
        2'b10:   r_out <= r_out + 4'd1;
        2'b01:   r_out <= r_out - 4'd1;
        default: r_out <= r_out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_theta <= '0;
      r_shake <= 1'b0;
      r_bdone <= 1'b0;
    end else begin
      r_shake <= w_issue;
      r_bdone <= (r_state == DRAIN) && (r_out == '0);
      if (w_issue) r_theta <= w_theta;
    end
  end

  assign theta       = r_theta;
  assign rand_shake  = r_shake;
  assign busy        = (r_state != IDLE);
  assign burst_done  = r_bdone;
  assign outstanding = r_out;

endmodule

// File: tb/tb_cordic_theta_gen.sv
// Directed checks of cordic_theta_gen: NCO/random thetas, credit limiting,
// abort/drain and async reset. Inputs change and outputs are sampled on negedge.
module tb_cordic_theta_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic [26:0] phase_init = '0, phase_step = '0;
  logic [31:0] seed = '0;
  logic        seed_load = 1'b0;

  logic        start = 1'b0, abort = 1'b0, done_i = 1'b0;
  logic [15:0] len = '0;
  logic [31:0] theta;
  logic        rand_shake, busy, burst_done;
  logic [3:0]  outstanding;

  logic        start4 = 1'b0, abort4 = 1'b0, done4 = 1'b0;
  logic [15:0] len4 = '0;
  logic [31:0] theta4;
  logic        shake4, busy4, bd4;
  logic [3:0]  out4;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [8];

  always #5 clk = ~clk;

  cordic_theta_gen #(.MAX_OUTSTANDING(1), .LEN_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .len(len),
    .phase_init(phase_init), .phase_step(phase_step), .seed(seed), .seed_load(seed_load),
    .done_i(done_i), .theta(theta), .rand_shake(rand_shake), .busy(busy),
    .burst_done(burst_done), .outstanding(outstanding));

  cordic_theta_gen #(.MAX_OUTSTANDING(4), .LEN_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .mode(mode), .len(len4),
    .phase_init(phase_init), .phase_step(phase_step), .seed(seed), .seed_load(seed_load),
    .done_i(done4), .theta(theta4), .rand_shake(shake4), .busy(busy4),
    .burst_done(bd4), .outstanding(out4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_shake(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rand_shake && n < 60);
  endtask

  // Burst on dut1 with done_i returned `gap` cycles after each rand_shake.
  task automatic burst1(input string tag, input int n, input int gap);
    int w, extra, bd;
    len = 16'(n); start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      wait_shake(w);
      chk({tag, "_shake"}, 32'(rand_shake), 32'd1);
      chk({tag, "_lat"}, 32'(w), 32'd1);
      chk({tag, "_theta"}, theta, exp_q[i]);
      extra = 0;
      repeat (gap) begin
        tick();
        if (rand_shake) extra++;
      end
      chk({tag, "_early"}, 32'(extra), 32'd0);
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
    end
    bd = 0;
    repeat (6) begin
      tick();
      if (burst_done) bd++;
    end
    chk({tag, "_bdone"}, 32'(bd), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int w, cnt, first, last, extra, bd;
    repeat (3) tick();
    chk("rst_theta", theta, 32'd0);
    chk("rst_flags", {28'd0, rand_shake, busy, burst_done, 1'b0}, 32'd0);
    chk("rst_out", 32'(outstanding), 32'd0);
    chk("rst_out4", 32'(out4), 32'd0);
    rst_n = 1'b1;
    tick();

    // done_i with nothing outstanding must not underflow; len=0 start ignored
    done_i = 1'b1; len = '0; start = 1'b1;
    tick();
    done_i = 1'b0; start = 1'b0;
    tick();
    chk("underflow", 32'(outstanding), 32'd0);
    chk("len0_busy", 32'(busy), 32'd0);

    // NCO quarter steps, wrap back to 0
    mode = 1'b0; phase_init = '0; phase_step = 27'(90 << 16);
    exp_q[0] = 32'h0000000; exp_q[1] = 32'h05A0000; exp_q[2] = 32'h0B40000;
    exp_q[3] = 32'h10E0000; exp_q[4] = 32'h0000000;
    burst1("nco90", 5, 20);

    // NCO wrap with remainder
    phase_init = 27'(350 << 16); phase_step = 27'(20 << 16);
    exp_q[0] = 32'h15E0000; exp_q[1] = 32'h00A0000; exp_q[2] = 32'h01E0000;
    burst1("ncowrap", 3, 0);

    // Random: zero seed loads 1
    mode = 1'b1; seed = '0; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    exp_q[0] = 32'h00000001; exp_q[1] = 32'h00B40003; exp_q[2] = 32'h010E0002;
    burst1("rnd0", 3, 2);

    seed = 32'h12345678; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    exp_q[0] = 32'h00195678;
    burst1("rndseed", 1, 0);

    // Credit limit with MAX_OUTSTANDING=4
    mode = 1'b0; phase_init = '0; phase_step = 27'(1 << 16);
    len4 = 16'd8; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    cnt = 0; first = 0; last = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (shake4) begin
        if (cnt == 0) first = i;
        last = i;
        cnt++;
      end
    end
    chk("cr_count", 32'(cnt), 32'd4);
    chk("cr_first", 32'(first), 32'd1);
    chk("cr_last", 32'(last), 32'd4);
    chk("cr_out", 32'(out4), 32'd4);
    chk("cr_busy", 32'(busy4), 32'd1);
    done4 = 1'b1;
    tick();
    done4 = 1'b0;
    tick();
    chk("cr_one_shake", 32'(shake4), 32'd1);
    chk("cr_one_theta", theta4, 32'h0040000);
    extra = 0;
    repeat (5) begin
      tick();
      if (shake4) extra++;
    end
    chk("cr_one_only", 32'(extra), 32'd0);
    chk("cr_out_again", 32'(out4), 32'd4);
    done4 = 1'b1;
    repeat (30) tick();
    done4 = 1'b0;
    tick();
    chk("cr_end_busy", 32'(busy4), 32'd0);
    chk("cr_end_out", 32'(out4), 32'd0);

    // Abort after 2 of 6 issues
    phase_init = '0; phase_step = 27'(10 << 16);
    len = 16'd6; start = 1'b1;
    tick();
    start = 1'b0;
    wait_shake(w);
    chk("ab_s1", 32'(rand_shake), 32'd1);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    wait_shake(w);
    chk("ab_s2", 32'(rand_shake), 32'd1);
    chk("ab_s2_theta", theta, 32'h00A0000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd1);
    chk("ab_out", 32'(outstanding), 32'd1);
    extra = 0;
    repeat (5) begin
      tick();
      if (rand_shake) extra++;
    end
    chk("ab_drain_busy", 32'(busy), 32'd1);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    bd = 0;
    repeat (6) begin
      tick();
      if (burst_done) bd++;
      if (rand_shake) extra++;
    end
    chk("ab_noissue", 32'(extra), 32'd0);
    chk("ab_bdone", 32'(bd), 32'd1);
    chk("ab_idle", 32'(busy), 32'd0);

    // Async reset mid-burst, then a fresh burst from phase_init
    phase_init = 27'(100 << 16);
    len = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    wait_shake(w);
    chk("rs_theta_pre", theta, 32'h0640000);
    chk("rs_out_pre", 32'(outstanding), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_theta", theta, 32'd0);
    chk("rs_flags", {28'd0, rand_shake, busy, burst_done, 1'b0}, 32'd0);
    chk("rs_out", 32'(outstanding), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q[0] = 32'h0640000; exp_q[1] = 32'h06E0000;
    burst1("rs_new", 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
